// File: rtl/hazard_ctrl_unit.sv
// Hazard/stall controller: load-use stalls, memory freeze, taken-branch flush.
// Optional perf counters are built only when HU_PERF_CNT_EN is defined.
module hazard_ctrl_unit #(
    parameter int REG_AW   = 2,
    parameter int LOAD_LAT = 1,
    parameter int CNT_W    = 16
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic [REG_AW-1:0] if_id_ra,
    input  logic [REG_AW-1:0] if_id_rb,
    input  logic              if_id_ra_used,
    input  logic              if_id_rb_used,
    input  logic [REG_AW-1:0] id_ex_rd,
    input  logic              id_ex_mem_read,
    input  logic              bt,
    input  logic              mem_busy,
    output logic              pc_en,
    output logic              if_id_en,
    output logic              id_ex_en,
    output logic              ex_mem_en,
    output logic              if_id_flush,
    output logic              id_ex_flush,
    output logic [CNT_W-1:0]  stall_cnt,
    output logic [CNT_W-1:0]  flush_cnt
);

    localparam int CW = $clog2(LOAD_LAT + 1);
    localparam logic [CW-1:0] LL_M1 = CW'(LOAD_LAT - 1);
    localparam logic [CW-1:0] ONE   = CW'(1);

    typedef enum logic [1:0] {RUN, LU_STALL, MEM_WAIT} state_e;

    state_e        state_q, state_d;
    state_e        ret_q, ret_d;
    state_e        eff;
    logic [CW-1:0] lu_cnt_q, lu_cnt_d;
    logic          hz;

    assign hz = id_ex_mem_read &
                ((if_id_ra_used & (if_id_ra == id_ex_rd)) |
                 (if_id_rb_used & (if_id_rb == id_ex_rd)));

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q  <= RUN;
            ret_q    <= RUN;
            lu_cnt_q <= '0;
        end else begin
            state_q  <= state_d;
            ret_q    <= ret_d;
            lu_cnt_q <= lu_cnt_d;
        end
    end

    always_comb begin
        pc_en       = 1'b1;
        if_id_en    = 1'b1;
        id_ex_en    = 1'b1;
        ex_mem_en   = 1'b1;
        if_id_flush = 1'b0;
        id_ex_flush = 1'b0;
        state_d     = state_q;
        ret_d       = ret_q;
        lu_cnt_d    = lu_cnt_q;
        // The first non-busy cycle after a freeze behaves as the saved state.
        eff = (state_q == MEM_WAIT) ? ret_q : state_q;
        if (!rst_n) begin
            pc_en     = 1'b0;
            if_id_en  = 1'b0;
            id_ex_en  = 1'b0;
            ex_mem_en = 1'b0;
        end else if (mem_busy) begin
            pc_en     = 1'b0;
            if_id_en  = 1'b0;
            id_ex_en  = 1'b0;
            ex_mem_en = 1'b0;
            state_d   = MEM_WAIT;
            ret_d     = eff;
        end else if (bt) begin
            if_id_flush = 1'b1;
            id_ex_flush = 1'b1;
            lu_cnt_d    = '0;
            state_d     = RUN;
        end else begin
            state_d = eff;
            unique case (eff)
                RUN: begin
                    if (hz) begin
                        pc_en       = 1'b0;
                        if_id_en    = 1'b0;
                        id_ex_flush = 1'b1;
                        if (LOAD_LAT > 1) begin
                            lu_cnt_d = LL_M1;
                            state_d  = LU_STALL;
                        end
                    end
                end
                LU_STALL: begin
                    pc_en       = 1'b0;
                    if_id_en    = 1'b0;
                    id_ex_flush = 1'b1;
                    lu_cnt_d    = lu_cnt_q - ONE;
                    if (lu_cnt_q == ONE) state_d = RUN;
                end
                default: state_d = RUN;
            endcase
        end
    end

`ifdef HU_PERF_CNT_EN
    logic [CNT_W-1:0] stall_cnt_q, stall_cnt_d;
    logic [CNT_W-1:0] flush_cnt_q, flush_cnt_d;

    always_comb begin
        stall_cnt_d = stall_cnt_q;
        flush_cnt_d = flush_cnt_q;
        if (!pc_en && (stall_cnt_q != '1)) stall_cnt_d = stall_cnt_q + 1'b1;
        if (bt && !mem_busy && (flush_cnt_q != '1))
            flush_cnt_d = flush_cnt_q + 1'b1;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            stall_cnt_q <= '0;
            flush_cnt_q <= '0;
        end else begin
            stall_cnt_q <= stall_cnt_d;
            flush_cnt_q <= flush_cnt_d;
        end
    end

    assign stall_cnt = stall_cnt_q;
    assign flush_cnt = flush_cnt_q;
`else
    assign stall_cnt = '0;
    assign flush_cnt = '0;
`endif

endmodule

// File: tb/tb_hazard_ctrl_unit.sv
// Bench for hazard_ctrl_unit: LOAD_LAT=1 and LOAD_LAT=3 instances side by side,
// plus a CNT_W=3 instance for counter saturation.
module tb_hazard_ctrl_unit;

    localparam logic [5:0] RN = 6'b111100;
    localparam logic [5:0] ST = 6'b001101;
    localparam logic [5:0] FZ = 6'b000000;
    localparam logic [5:0] FL = 6'b111111;
`ifdef HU_PERF_CNT_EN
    localparam bit PERF = 1'b1;
`else
    localparam bit PERF = 1'b0;
`endif

    typedef struct {
        logic [1:0] ra;
        logic [1:0] rb;
        logic       rau;
        logic       rbu;
        logic [1:0] rd;
        logic       mr;
        logic       bt;
        logic       busy;
        logic [5:0] e1;
        logic [5:0] e3;
    } vec_t;

    logic       clk;
    logic       rst_n;
    logic [1:0] ra, rb, rd;
    logic       rau, rbu, mr, bt, busy;
    logic [5:0] o1, o3, os;
    logic [15:0] sc1, fc1, sc3, fc3;
    logic [2:0]  scs, fcs;

    int n_vec;
    int n_bad;
    vec_t tv[$];

    hazard_ctrl_unit #(.REG_AW(2), .LOAD_LAT(1), .CNT_W(16)) u1 (
        .clk(clk), .rst_n(rst_n),
        .if_id_ra(ra), .if_id_rb(rb),
        .if_id_ra_used(rau), .if_id_rb_used(rbu),
        .id_ex_rd(rd), .id_ex_mem_read(mr),
        .bt(bt), .mem_busy(busy),
        .pc_en(o1[5]), .if_id_en(o1[4]),
        .id_ex_en(o1[3]), .ex_mem_en(o1[2]),
        .if_id_flush(o1[1]), .id_ex_flush(o1[0]),
        .stall_cnt(sc1), .flush_cnt(fc1)
    );

    hazard_ctrl_unit #(.REG_AW(2), .LOAD_LAT(3), .CNT_W(16)) u3 (
        .clk(clk), .rst_n(rst_n),
        .if_id_ra(ra), .if_id_rb(rb),
        .if_id_ra_used(rau), .if_id_rb_used(rbu),
        .id_ex_rd(rd), .id_ex_mem_read(mr),
        .bt(bt), .mem_busy(busy),
        .pc_en(o3[5]), .if_id_en(o3[4]),
        .id_ex_en(o3[3]), .ex_mem_en(o3[2]),
        .if_id_flush(o3[1]), .id_ex_flush(o3[0]),
        .stall_cnt(sc3), .flush_cnt(fc3)
    );

    hazard_ctrl_unit #(.REG_AW(2), .LOAD_LAT(3), .CNT_W(3)) us (
        .clk(clk), .rst_n(rst_n),
        .if_id_ra(ra), .if_id_rb(rb),
        .if_id_ra_used(rau), .if_id_rb_used(rbu),
        .id_ex_rd(rd), .id_ex_mem_read(mr),
        .bt(bt), .mem_busy(busy),
        .pc_en(os[5]), .if_id_en(os[4]),
        .id_ex_en(os[3]), .ex_mem_en(os[2]),
        .if_id_flush(os[1]), .id_ex_flush(os[0]),
        .stall_cnt(scs), .flush_cnt(fcs)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic chk(input string nm, input logic [31:0] act,
                       input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp,
                     $time);
        end
    endtask

    function automatic void add(input logic [1:0] a, input logic [1:0] b,
                                input logic au, input logic bu,
                                input logic [1:0] d, input logic m,
                                input logic t, input logic y,
                                input logic [5:0] x1, input logic [5:0] x3);
        vec_t v;
        v.ra = a; v.rb = b; v.rau = au; v.rbu = bu; v.rd = d;
        v.mr = m; v.bt = t; v.busy = y; v.e1 = x1; v.e3 = x3;
        tv.push_back(v);
    endfunction

    task automatic idle();
        ra = 2'd2; rb = 2'd3; rau = 1'b1; rbu = 1'b1;
        rd = 2'd1; mr = 1'b0; bt = 1'b0; busy = 1'b0;
    endtask

    initial begin
        n_vec = 0;
        n_bad = 0;
        // load-use hazards, branch cancel, freeze mid-stall, bt held in freeze
        add(2, 3, 1, 1, 1, 1, 0, 0, RN, RN);
        add(2, 3, 1, 1, 1, 0, 0, 0, RN, RN);
        add(2, 3, 1, 1, 2, 1, 0, 0, ST, ST);
        add(2, 3, 1, 1, 2, 0, 0, 0, RN, ST);
        add(2, 3, 1, 1, 1, 0, 0, 0, RN, ST);
        add(2, 3, 1, 1, 1, 0, 0, 0, RN, RN);
        add(2, 3, 0, 1, 2, 1, 0, 0, RN, RN);
        add(0, 2, 1, 1, 2, 1, 0, 0, ST, ST);
        add(2, 3, 1, 1, 1, 0, 1, 0, FL, FL);
        add(2, 3, 1, 1, 1, 0, 0, 0, RN, RN);
        add(2, 3, 1, 1, 2, 1, 0, 0, ST, ST);
        add(2, 3, 1, 1, 2, 1, 0, 1, FZ, FZ);
        add(2, 3, 1, 1, 1, 0, 0, 1, FZ, FZ);
        add(2, 3, 1, 1, 1, 0, 0, 1, FZ, FZ);
        add(2, 3, 1, 1, 1, 0, 0, 1, FZ, FZ);
        add(2, 3, 1, 1, 1, 0, 0, 0, RN, ST);
        add(2, 3, 1, 1, 1, 0, 0, 0, RN, ST);
        add(2, 3, 1, 1, 1, 0, 0, 0, RN, RN);
        add(2, 3, 1, 1, 1, 0, 1, 1, FZ, FZ);
        add(2, 3, 1, 1, 1, 0, 1, 0, FL, FL);
        add(2, 3, 1, 1, 1, 0, 0, 0, RN, RN);

        rst_n = 1'b0;
        idle();
        @(negedge clk);
        #1;
        chk("rst_out1", 32'(o1), 32'(FZ));
        chk("rst_out3", 32'(o3), 32'(FZ));
        chk("rst_stall3", 32'(sc3), 32'd0);
        chk("rst_flush3", 32'(fc3), 32'd0);
        @(negedge clk);
        rst_n = 1'b1;

        for (int i = 0; i < tv.size(); i++) begin
            ra = tv[i].ra; rb = tv[i].rb;
            rau = tv[i].rau; rbu = tv[i].rbu;
            rd = tv[i].rd; mr = tv[i].mr;
            bt = tv[i].bt; busy = tv[i].busy;
            #1;
            chk($sformatf("v%0d_lat1", i), 32'(o1), 32'(tv[i].e1));
            chk($sformatf("v%0d_lat3", i), 32'(o3), 32'(tv[i].e3));
            @(negedge clk);
        end
        idle();
        #1;
        chk("stall_cnt1", 32'(sc1), PERF ? 32'd8 : 32'd0);
        chk("stall_cnt3", 32'(sc3), PERF ? 32'd12 : 32'd0);
        chk("flush_cnt3", 32'(fc3), PERF ? 32'd2 : 32'd0);
        chk("stall_sat", 32'(scs), PERF ? 32'd7 : 32'd0);
        @(negedge clk);

        // reset asserted while frozen inside a load stall
        rd = 2'd2; mr = 1'b1;
        #1;
        chk("seqA_hz", 32'(o3), 32'(ST));
        @(negedge clk);
        idle();
        busy = 1'b1;
        #1;
        chk("seqA_busy", 32'(o3), 32'(FZ));
        @(negedge clk);
        #2;
        busy = 1'b0;
        rst_n = 1'b0;
        #1;
        chk("seqA_rst_out", 32'(o3), 32'(FZ));
        chk("seqA_rst_stall", 32'(sc3), 32'd0);
        @(negedge clk);
        rst_n = 1'b1;
        #1;
        chk("seqA_rel1", 32'(o3), 32'(RN));
        chk("seqA_rel1_lat1", 32'(o1), 32'(RN));
        @(negedge clk);
        #1;
        chk("seqA_rel2", 32'(o3), 32'(RN));
        @(negedge clk);

        // ten back-to-back taken branches
        bt = 1'b1;
        for (int k = 0; k < 10; k++) begin
            #1;
            chk($sformatf("seqB_bt%0d", k), 32'(o3), 32'(FL));
            @(negedge clk);
        end
        bt = 1'b0;
        #1;
        chk("flush_sat", 32'(fcs), PERF ? 32'd7 : 32'd0);
        chk("flush_cnt10", 32'(fc3), PERF ? 32'd10 : 32'd0);
        chk("stall_after_rst", 32'(scs), 32'd0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end

endmodule
